muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit implementing ALU function group 11 (MULT, MULTU, DIV, DIVU), which the combinational ALU returns as zero. It accepts a request from the execute stage, runs a 32-step radix-2 shift/add or restoring-division loop, and returns a 64-bit result in HI/LO registers. The pipeline stalls on `busy` and reads `hi`/`lo` after `done`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: single clock, all state on rising edge.
- `clrn` input 1: reset, asynchronous, active-low.
- `start` input 1: request strobe, sampled only in IDLE.
- `func` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (equals alufunc[1:0] of codes 11xx).
- `dataa` input 32: multiplicand / dividend.
- `datab` input 32: multiplier / divisor.
- `flush` input 1: synchronous abort from the exception logic.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when `hi`/`lo` are updated.
- `hi` output 32: product[63:32] or remainder.
- `lo` output 32: product[31:0] or quotient.
- `div_zero` output 1: registered flag, set with `done` when a DIV/DIVU had `datab`==0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `busy`=0. If `start`=1 at an edge, latch `func`, latch operands (signed ops store magnitudes and result sign bits), clear the 6-bit step counter, and go to CALC. Exception: a DIV/DIVU with `datab`==0 goes directly to DONE.
- CALC: one iteration per cycle for 32 cycles, counter 0..31, then go to FIX.
  - Multiply: 64-bit accumulator; if multiplier LSB is 1, add the multiplicand to the upper half with carry; then shift right by 1.
  - Divide: restoring; shift {rem,quot} left by 1; trial-subtract the divisor from rem (33-bit); if non-negative, keep the result and set quot LSB.
- FIX: apply signs for MULT/DIV.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is truncated toward zero (negated if signs differ); remainder takes the sign of the dividend.
  - Unsigned ops pass through unchanged. Go to DONE.
- DONE: write `hi`/`lo`/`div_zero`, pulse `done`, return to IDLE.
- Divide by zero: `hi`=`dataa`, `lo`=32'hFFFFFFFF, `div_zero`=1.
- Overflow case: DIV of 32'h80000000 by 32'hFFFFFFFF gives `lo`=32'h80000000, `hi`=0, `div_zero`=0, with no trap.
- `start` while `busy`=1 is ignored, with no queueing.
- `flush`=1 in any state returns the unit to IDLE next edge. `hi`/`lo`/`div_zero` keep their previous values and `done` is not pulsed. `flush` takes priority over `start` in the same cycle.
- `hi`/`lo`/`div_zero` change only in DONE. They hold their values across IDLE indefinitely.

## Timing
- Reset (`clrn`=0, asynchronous) values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_zero`=0, counter 0. Reset mid-operation discards all progress.
- `busy` is registered. It rises the edge after `start` is accepted and falls on the same edge that `done` rises.
- Normal latency: start sampled at edge E0; CALC occupies E1..E32; FIX at E33; DONE at E34. `done`=1 and new `hi`/`lo` are visible in the cycle after E34.
  - Total: 35 cycles start-to-done, 36 cycles start-to-next-accept.
- Divide-by-zero latency: `done` is high the cycle after E1, giving 2 cycles.
- A new `start` may be presented in the same cycle `done`=1, because the state is IDLE; it is accepted at that edge.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> after 35 cycles `done`=1, `hi`=32'hFFFFFFFE, `lo`=32'h00000001, `busy` high for exactly 34 cycles.
- MULT -7 (32'hFFFFFFF9) × 6 -> `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFD6; MULT 32'h80000000 × 32'h80000000 -> `hi`=32'h40000000, `lo`=0.
- DIV -7 ÷ 2 -> `lo`=32'hFFFFFFFD (-3), `hi`=32'hFFFFFFFF (-1); DIVU 100 ÷ 7 -> `lo`=14, `hi`=2; DIV 32'h80000000 ÷ -1 -> `lo`=32'h80000000, `hi`=0.
- DIVU 5 ÷ 0 -> `done` 2 cycles after start, `div_zero`=1, `hi`=5, `lo`=32'hFFFFFFFF; a following MULTU 3×4 clears `div_zero` and gives `lo`=12.
- `start` pulsed at cycle 10 of a running MULTU is ignored; `flush` at cycle 20 of a DIVU -> IDLE next edge, no `done`, `hi`/`lo` unchanged from the prior result.
- `clrn` asserted asynchronously mid-CALC -> `busy`, `done`, `hi`, `lo`, `div_zero` all 0 immediately; back-to-back start in the `done` cycle is accepted with no idle gap.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit for ALU group 11
// (MULT, MULTU, DIV, DIVU). It runs a 32-step radix-2 shift/add multiply or
// a restoring divide, then applies the signs, and returns a 64-bit result
// as hi/lo. The pipeline stalls on busy and reads hi/lo once done pulses.
module muldiv_unit (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  func,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Two's-complement negation helpers, used for magnitudes and sign fix-up
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_func;
  logic [63:0] r_acc;     // multiply: {upper, multiplier}; divide: {rem, quot}
  logic [31:0] r_opb;     // multiplicand or divisor magnitude
  logic        r_neg_q;   // product / quotient must be negated
  logic        r_neg_r;   // remainder must be negated (dividend was negative)
  logic        r_dz;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_div_zero;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [32:0] w_rem_sh;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_step;
  logic [63:0] w_fix;

  // Operand magnitudes, one iteration of each algorithm, and the sign fix-up
  always_comb begin
    w_a_neg    = ~func[0] & dataa[31];
    w_b_neg    = ~func[0] & datab[31];
    w_a_mag    = w_a_neg ? neg32(dataa) : dataa;
    w_b_mag    = w_b_neg ? neg32(datab) : datab;

    // Multiply: conditional add into the upper half, then shift right with carry
    w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
    w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // Divide: the shifted remainder can be 33 bits wide, so compare at 33 bits;
    // when the trial succeeds the difference always fits in 32 bits
    w_rem_sh   = r_acc[63:31];
    w_div_ge   = (w_rem_sh >= {1'b0, r_opb});
    w_div_diff = r_acc[62:31] - r_opb;
    w_div_step = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                          : {r_acc[62:0], 1'b0};

    case (r_func)
      2'b00:   w_fix = r_neg_q ? neg64(r_acc) : r_acc;
      2'b10:   w_fix = {(r_neg_r ? neg32(r_acc[63:32]) : r_acc[63:32]),
                        (r_neg_q ? neg32(r_acc[31:0])  : r_acc[31:0])};
      default: w_fix = r_acc;
    endcase
  end

  // Control FSM and datapath registers; flush aborts without touching hi/lo
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= IDLE;
      r_cnt      <= 6'd0;
      r_func     <= 2'b00;
      r_acc      <= 64'd0;
      r_opb      <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_div_zero <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_func  <= func;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (func[1] && (datab == 32'd0)) begin
              // Divide by zero skips the loop entirely
              r_acc   <= {dataa, 32'hFFFF_FFFF};
              r_opb   <= 32'd0;
              r_dz    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_acc   <= {32'd0, (func[1] ? w_a_mag : w_b_mag)};
              r_opb   <= func[1] ? w_b_mag : w_a_mag;
              r_dz    <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= r_func[1] ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_acc   <= w_fix;
          r_state <= DONE;
        end
        DONE: begin
          r_hi       <= r_acc[63:32];
          r_lo       <= r_acc[31:0];
          r_div_zero <= r_dz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [1:0]  func;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_tests;
  int n_fail;

  muldiv_unit dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .func     (func),
    .dataa    (dataa),
    .datab    (datab),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; starts an op, returns start-to-done latency and busy cycles.
  // If inj_at > 0, a competing DIVU start is pulsed at that cycle of the run.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, output int lat, output int bcnt);
    func  = f;
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == inj_at) begin
        start = 1'b1;
        func  = 2'b11;
        dataa = 32'd1;
        datab = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  int  lat;
  int  bcnt;
  bit  seen_done;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clrn    = 1'b0;
    start   = 1'b0;
    func    = 2'b00;
    dataa   = 32'd0;
    datab   = 32'd0;
    flush   = 1'b0;
    #12;
    chk("reset_outputs", {busy, done, div_zero, hi, lo}, 67'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // MULTU all-ones squared, with full latency and busy-width checks
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcnt);
    chk("multu_lat", lat, 64'd35);
    chk("multu_busy", bcnt, 64'd34);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_busy_low", busy, 64'd0);

    run_op(2'b00, 32'hFFFF_FFF9, 32'd6, 0, lat, bcnt);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, lat, bcnt);
    chk("mult_min", {hi, lo}, 64'h4000_0000_0000_0000);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt);
    chk("div_negdivisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, 0, lat, bcnt);
    chk("divu", {hi, lo}, 64'h0000_0002_0000_000E);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt);
    chk("div_ovf", {div_zero, hi, lo}, 65'h0_0000_0000_8000_0000);

    // Divide by zero, then a multiply clears the flag
    run_op(2'b11, 32'd5, 32'd0, 0, lat, bcnt);
    chk("dz_lat", lat, 64'd2);
    chk("dz_res", {div_zero, hi, lo}, 65'h1_0000_0005_FFFF_FFFF);
    run_op(2'b01, 32'd3, 32'd4, 0, lat, bcnt);
    chk("dz_clear", {div_zero, hi, lo}, 65'h0_0000_0000_0000_000C);

    // Back-to-back: start in the done cycle is accepted immediately
    run_op(2'b11, 32'd100, 32'd7, 0, lat, bcnt);
    chk("b2b_lat", lat, 64'd35);
    chk("b2b_res", {hi, lo}, 64'h0000_0002_0000_000E);

    // Start during a running MULTU is ignored
    run_op(2'b01, 32'd3, 32'd4, 10, lat, bcnt);
    chk("ign_lat", lat, 64'd35);
    chk("ign_res", {hi, lo}, 64'h0000_0000_0000_000C);
    repeat (40) @(negedge clk);
    chk("ign_no_queue", {busy, hi, lo}, 65'h0_0000_0000_0000_000C);

    // Flush at cycle 20 of a DIVU: no done, result unchanged
    func  = 2'b11;
    dataa = 32'd100;
    datab = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", busy, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("flush_no_done", seen_done, 64'd0);
    chk("flush_hold", {hi, lo}, 64'h0000_0000_0000_000C);

    // Flush beats start in the same cycle
    func  = 2'b01;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_prio", busy, 64'd0);

    // Asynchronous reset mid-CALC clears everything immediately
    run_op(2'b11, 32'd9, 32'd0, 0, lat, bcnt);
    chk("dz2_res", {div_zero, hi, lo}, 65'h1_0000_0009_FFFF_FFFF);
    func  = 2'b01;
    dataa = 32'd3;
    datab = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk("async_reset", {busy, done, div_zero, hi, lo}, 67'd0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (40) @(negedge clk);
    chk("reset_discard", {busy, done, hi, lo}, 66'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
